// File: rtl/quad_poly_eval.sv
// quad_poly_eval
//   Multi-cycle evaluator of F = K + sum_i (Q_i*x_i^2 + L_i*x_i) over N_CH
//   unsigned channels. Each channel is evaluated in Horner form,
//   x*(Q*x + L), using one shared signed multiplier over two cycles.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   input word valid
//   in_ready   block can accept (high only while idle)
//   in_data    N_CH*IN_W unsigned inputs, channel 0 in the LSBs
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts the result
//   out        OUT_W-bit signed result
//   sat        result was clamped (QPE_SAT_EN builds only, else 0)
//
// Configuration
//   QPE_SAT_EN  when defined, the result is clamped to the OUT_W signed
//               range and sat reports the clamp; otherwise out wraps.
module quad_poly_eval #(
  parameter int                        N_CH   = 3,
  parameter int                        IN_W   = 4,
  parameter int                        COEF_W = 8,
  parameter int                        OUT_W  = 19,
  parameter logic [N_CH*COEF_W-1:0]    COEF_Q = 24'h06FC05,
  parameter logic [N_CH*COEF_W-1:0]    COEF_L = 24'hFE0308,
  parameter logic signed [COEF_W-1:0]  COEF_K = COEF_W'(13)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_CH*IN_W-1:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out,
  output logic                   sat
);

  // t holds Q*x + L; the product of the shared multiplier is x times a
  // T_W-bit operand; the accumulator is wide enough never to overflow.
  localparam int T_W   = IN_W + COEF_W + 2;
  localparam int P_W   = T_W + IN_W + 1;
  localparam int ACC_W = 2*IN_W + COEF_W + $clog2(N_CH+1) + 2;
  localparam int EXT_W = (OUT_W > ACC_W) ? OUT_W : ACC_W;
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(N_CH-1);

  typedef enum logic [1:0] {IDLE, MUL1, MUL2, DONE} state_t;

  state_t                   state_reg;
  logic [N_CH*IN_W-1:0]     x_cap_reg;
  logic [CH_W-1:0]          ch_reg;
  logic signed [T_W-1:0]    t_reg;
  logic signed [ACC_W-1:0]  acc_reg;
  logic                     in_ready_reg;
  logic                     out_valid_reg;
  logic [OUT_W-1:0]         out_reg;

  // Per-channel views of the captured inputs and the coefficient constants.
  logic [IN_W-1:0]          x_arr [N_CH];
  logic signed [COEF_W-1:0] q_arr [N_CH];
  logic signed [COEF_W-1:0] l_arr [N_CH];

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      assign x_arr[gi] = x_cap_reg[gi*IN_W +: IN_W];
      assign q_arr[gi] = COEF_Q[gi*COEF_W +: COEF_W];
      assign l_arr[gi] = COEF_L[gi*COEF_W +: COEF_W];
    end
  endgenerate

  // Shared multiplier: MUL1 forms Q*x, MUL2 forms x*t. x is zero-extended
  // by one bit so it stays non-negative in the signed product.
  logic signed [IN_W:0]     mul_x;
  logic signed [T_W-1:0]    mul_a;
  logic signed [P_W-1:0]    prod;
  logic signed [T_W-1:0]    t_next;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [EXT_W-1:0]  acc_ext;

  assign mul_x   = $signed({1'b0, x_arr[ch_reg]});
  assign mul_a   = (state_reg == MUL1) ? T_W'(q_arr[ch_reg]) : t_reg;
  assign prod    = P_W'(mul_a) * P_W'(mul_x);
  assign t_next  = $signed(prod[T_W-1:0]) + T_W'(l_arr[ch_reg]);
  assign acc_sum = acc_reg + ACC_W'(prod);
  assign acc_ext = EXT_W'(acc_sum);

  // Bits of the extended sum above OUT_W are only consumed by the clamp.
  logic unused_acc_bits;
  assign unused_acc_bits = ^acc_ext;

  logic [OUT_W-1:0] out_next;

`ifdef QPE_SAT_EN
  localparam logic signed [EXT_W-1:0] OUT_MAX =
    {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] OUT_MIN =
    {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic sat_reg;
  logic sat_next;

  always_comb begin
    out_next = acc_ext[OUT_W-1:0];
    sat_next = 1'b0;
    if (acc_ext > OUT_MAX) begin
      out_next = {1'b0, {(OUT_W-1){1'b1}}};
      sat_next = 1'b1;
    end else if (acc_ext < OUT_MIN) begin
      out_next = {1'b1, {(OUT_W-1){1'b0}}};
      sat_next = 1'b1;
    end
  end

  assign sat = sat_reg;
`else
  assign out_next = acc_ext[OUT_W-1:0];
  assign sat      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      x_cap_reg     <= '0;
      ch_reg        <= '0;
      t_reg         <= '0;
      acc_reg       <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      out_reg       <= '0;
`ifdef QPE_SAT_EN
      sat_reg       <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            x_cap_reg    <= in_data;
            acc_reg      <= ACC_W'(COEF_K);
            ch_reg       <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= MUL1;
          end
        end
        MUL1: begin
          t_reg     <= t_next;
          state_reg <= MUL2;
        end
        MUL2: begin
          acc_reg <= acc_sum;
          if (ch_reg == CH_LAST) begin
            out_reg       <= out_next;
`ifdef QPE_SAT_EN
            sat_reg       <= sat_next;
`endif
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            ch_reg    <= ch_reg + CH_W'(1);
            state_reg <= MUL1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out       = out_reg;

endmodule

// File: tb/tb_quad_poly_eval.sv
// Testbench for quad_poly_eval: a default-parameter instance checked every
// cycle against a cycle-count/arithmetic model, plus two reconfigured
// instances (single channel; narrow output) checked with literal values.
module tb_quad_poly_eval;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Default instance
  logic        in_valid, in_ready, out_valid, out_ready, sat;
  logic [11:0] in_data;
  logic [18:0] out;

  // Single-channel instance
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_sat;
  logic [3:0]  a_in_data;
  logic [18:0] a_out;

  // Narrow-output instance
  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_sat;
  logic [11:0] w_in_data;
  logic [9:0]  w_out;

  quad_poly_eval dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .sat(sat)
  );

  quad_poly_eval #(
    .N_CH(1), .COEF_Q(8'h02), .COEF_L(8'hFF), .COEF_K(8'h00)
  ) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out(a_out), .sat(a_sat)
  );

  quad_poly_eval #(
    .OUT_W(10)
  ) dut_w (
    .clk(clk), .rst(rst),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out(w_out), .sat(w_sat)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // ---------------- behavioural model (default parameters) ----------------
  int mq [3] = '{5, -4, 6};
  int ml [3] = '{8, 3, -2};

  function automatic int poly(input logic [11:0] d);
    int f;
    f = 13;
    for (int i = 0; i < 3; i++) begin
      int x;
      x = int'(d[i*4 +: 4]);
      f += mq[i]*x*x + ml[i]*x;
    end
    return f;
  endfunction

  function automatic logic [18:0] model_out(input logic [11:0] d);
    int f;
    f = poly(d);
`ifdef QPE_SAT_EN
    if (f > 262143) f = 262143;
    if (f < -262144) f = -262144;
`endif
    return f[18:0];
  endfunction

  function automatic logic model_sat(input logic [11:0] d);
    int f;
    f = poly(d);
`ifdef QPE_SAT_EN
    return (f > 262143) || (f < -262144);
`else
    return 1'b0;
`endif
  endfunction

  // Phase: 0 idle, 1 computing (counting edges since accept), 2 result held
  int          m_phase, m_cnt;
  logic [18:0] m_pend, m_out;
  logic        m_pend_sat, m_sat;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_cnt   <= 0;
      m_out   <= '0;
      m_sat   <= 1'b0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_pend     <= model_out(in_data);
          m_pend_sat <= model_sat(in_data);
          m_cnt      <= 0;
          m_phase    <= 1;
        end
        1: begin
          m_cnt <= m_cnt + 1;
          if (m_cnt + 1 == 2*3) begin
            m_phase <= 2;
            m_out   <= m_pend;
            m_sat   <= m_pend_sat;
          end
        end
        default: if (out_ready) m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    check("cyc_in_ready", 32'(in_ready), 32'(m_phase == 0));
    check("cyc_out_valid", 32'(out_valid), 32'(m_phase == 2));
    check("cyc_out", 32'(out), 32'(m_out));
    check("cyc_sat", 32'(sat), 32'(m_sat));
  end

  // ---------------- directed stimulus ----------------
  task automatic run_vec(input logic [3:0] x, input logic [3:0] y, input logic [3:0] z,
                         input int hold, input logic [18:0] exp_lit, input string tag);
    int n;
    check({tag, "_in_ready_before"}, 32'(in_ready), 32'd1);
    out_ready = (hold == 0);
    in_data   = {z, y, x};
    in_valid  = 1'b1;
    @(posedge clk); #1;
    check({tag, "_in_ready_after_accept"}, 32'(in_ready), 32'd0);
    n = 0;
    // Garbage on the inputs while busy must not disturb the computation.
    while (!out_valid && n < 40) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 12'($urandom);
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, 32'(n), 32'd6);
    check({tag, "_out"}, 32'(out), 32'(exp_lit));
    if (hold > 0) begin
      repeat (hold) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 12'($urandom);
        @(posedge clk); #1;
        check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_hold_out"}, 32'(out), 32'(exp_lit));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_valid_after_hs"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_after_hs"}, 32'(in_ready), 32'd1);
    check({tag, "_out_held"}, 32'(out), 32'(exp_lit));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_data = '0;
    w_in_valid = 1'b0; w_out_ready = 1'b0; w_in_data = '0;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_sat", 32'(sat), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_vec(4'd0,  4'd0,  4'd0,  0,  19'd13,    "zero");
    run_vec(4'd15, 4'd0,  4'd0,  0,  19'd1258,  "x15");
    run_vec(4'd0,  4'd15, 4'd0,  0,  19'h7FCB6, "y15");
    run_vec(4'd15, 4'd15, 4'd15, 10, 19'd1723,  "all15_bp");
    run_vec(4'd7,  4'd9,  4'd3,  3,  19'd65,    "mixed");

    // Abort in MUL2 of channel 1 (three edges after accept).
    in_data  = 12'hFFF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out", 32'(out), 32'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    run_vec(4'd1, 4'd1, 4'd1, 0, 19'd29, "after_abort");

    // Single-channel instance: 15*(2*15 - 1) = 435, two cycles of latency.
    check("a_in_ready", 32'(a_in_ready), 32'd1);
    a_in_data   = 4'd15;
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    n = 0;
    while (!a_out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("a_latency", 32'(n), 32'd2);
    check("a_out", 32'(a_out), 32'd435);
    check("a_sat", 32'(a_sat), 32'd0);
    @(posedge clk); #1;
    check("a_valid_done_one_cycle", 32'(a_out_valid), 32'd0);
    a_out_ready = 1'b0;

    // Narrow-output instance: 1723 does not fit in 10 signed bits.
    w_in_data   = 12'hFFF;
    w_out_ready = 1'b1;
    w_in_valid  = 1'b1;
    @(posedge clk); #1;
    w_in_valid = 1'b0;
    n = 0;
    while (!w_out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("w_latency", 32'(n), 32'd6);
`ifdef QPE_SAT_EN
    check("w_out", 32'(w_out), 32'h1FF);
    check("w_sat", 32'(w_sat), 32'd1);
`else
    check("w_out", 32'(w_out), 32'h2BB);
    check("w_sat", 32'(w_sat), 32'd0);
`endif
    @(posedge clk); #1;
    check("w_ready_after_hs", 32'(w_in_ready), 32'd1);
    w_out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/quad_poly_eval.md
# quad_poly_eval

Parametrised, multi-cycle evaluator of a separable quadratic polynomial F = K + Σ_i (Q_i·x_i² + L_i·x_i) over N_CH unsigned input channels. It replaces the fixed three-input, single-shot evaluator and adds a valid/ready handshake on both sides, a configurable channel count and width, and one shared multiplier sequenced by an FSM. It sits between the input capture logic and the result display/report path.

## Interface

Parameters:
- N_CH, 3: number of input channels (≥1).
- IN_W, 4: width of each unsigned input.
- COEF_W, 8: width of each signed coefficient.
- OUT_W, 19: width of the signed result.
- COEF_Q, 24'h06FC05: packed signed quadratic coefficients, channel 0 in the LSBs (default Q0=5, Q1=-4, Q2=6).
- COEF_L, 24'hFE0308: packed signed linear coefficients, channel 0 in the LSBs (default L0=8, L1=3, L2=-2).
- COEF_K, 13: signed constant, COEF_W bits.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- in_valid, input, 1: input word valid.
- in_ready, output, 1: block can accept; high only in IDLE.
- in_data, input, N_CH*IN_W: unsigned x_i, channel 0 in the LSBs.
- out_valid, output, 1: result valid; held until accepted.
- out_ready, input, 1: consumer accepts the result.
- out, output, OUT_W: signed result in two's complement.
- sat, output, 1: result was clamped (QPE_SAT_EN only; otherwise tied 0).

## Operation

- FSM states: IDLE, MUL1, MUL2, DONE. Reset state is IDLE.
- IDLE: in_ready=1. When in_valid=1, capture in_data, set acc←COEF_K (sign-extended), set ch←0, and go to MUL1.
- MUL1: t ← Q_ch·x_ch + L_ch, then go to MUL2.
- MUL2: acc ← acc + x_ch·t. If ch=N_CH-1, load out and sat from acc and go to DONE. Otherwise ch←ch+1 and go to MUL1.
- DONE: out_valid=1. When out_ready=1, go to IDLE. out and sat hold their values until the next result.
- Horner form per channel. There is one multiplier: the MUL1 and MUL2 products share it through a mux.
- Arithmetic: x_i is zero-extended and all operations are signed. t width is IN_W+COEF_W+2. acc width is ACC_W = 2·IN_W+COEF_W+$clog2(N_CH+1)+2, which is large enough that acc never overflows.
- Output: without saturation, out = acc[OUT_W-1:0], which wraps.
- in_valid outside IDLE is ignored and no data is captured.
- in_data is sampled only at the accept edge. Later changes to in_data do not affect the running computation.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out=0, sat=0. acc, t and ch reset to 0.
- Reset asserted mid-operation aborts the computation immediately. No out_valid pulse is produced.

## Timing

- The accept edge is edge 0. The result is registered at edge 2·N_CH, so out_valid rises 2·N_CH cycles after acceptance (6 with the default parameters).
- out_valid stays high for every cycle until a rising edge with out_ready=1. At that edge out_valid falls and in_ready rises.
- The earliest next accept is the edge after the out_ready handshake. Minimum throughput is one result per 2·N_CH+2 cycles.
- If out_ready is already high when out_valid rises, DONE lasts exactly one cycle.
- in_ready and out_valid are decoded from registered state only. Neither has a combinational path from in_valid or out_ready.

## Configuration

- QPE_SAT_EN defined: on the final MUL2 edge, acc is clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. sat=1 when clamping occurred, otherwise 0. sat is registered alongside out.
- QPE_SAT_EN undefined: out wraps (truncation), sat is tied to 0, and there is no clamp logic.

## Test plan

- Reset, then x=y=z=0 with out_ready=1 → out_valid exactly 6 cycles after accept; out=13; in_ready=0 during MUL1/MUL2/DONE.
- x=15, y=0, z=0 → out=1258. Then x=0, y=15, z=0 → out=-842 (19'h7FCB6). Then all inputs 15 → out=1723.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → out_valid and out stay stable and in_valid pulses are ignored. Raising out_ready → one handshake, then in_ready=1 on the next cycle.
- Reset asserted during MUL2 of channel 1 → out_valid=0, out=0, in_ready=1 immediately. A fresh x=1, y=1, z=1 then yields 5+8-4+3+6-2+13 = 29.
- OUT_W=10, all inputs 15: with QPE_SAT_EN → out=511, sat=1. Without QPE_SAT_EN → out=10'h2BB (-325), sat=0.
- N_CH=1, COEF_Q=8'h02, COEF_L=8'hFF, COEF_K=0, x=15 → out=435, out_valid 2 cycles after accept.
